// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one 32-bit ALU; one operation in flight,
// the response is returned on the channel of the port that was granted.
//   state | meaning
//   IDLE  | ready for a request, grant is combinational from req*_valid
//   EXEC  | ALU evaluates the registered operands
//   RESP  | response held until the owning port consumes it
module alu_share_arbiter #(
   parameter int PRIO_MODE  = 0,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [2:0]            req0_op,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_result,
   output logic [2:0]            rsp0_flags,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   input  logic [2:0]            req1_op,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_result,
   output logic [2:0]            rsp1_flags,
   output logic                  busy
);
   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            gid_q, gid_d;
   logic [MSB:0]    a_q, a_d, b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic [MSB:0]    result_q, result_d;
   logic [2:0]      flags_q, flags_d;

   logic            any_valid;
   logic            grant_id;
   logic [MSB+1:0]  sum, diff;
   logic            add_ovf, sub_ovf;
   logic [MSB:0]    alu_result;
   logic            alu_ovf, alu_carry;

   // Round-robin only matters when both ask; a lone requester always wins.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (PRIO_MODE == 1)
         grant_id = ~req0_valid;
      else if (req0_valid && req1_valid)
         grant_id = ~last_grant_q;
      else
         grant_id = ~req0_valid;
   end

   always_comb begin
      sum        = {1'b0, a_q} + {1'b0, b_q};
      diff       = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
      add_ovf    = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      sub_ovf    = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      alu_result = '0;
      alu_ovf    = 1'b0;
      alu_carry  = 1'b0;
      case (op_q)
         3'b000: alu_result = a_q & b_q;
         3'b001: alu_result = a_q | b_q;
         3'b010: begin
            alu_result = sum[MSB:0];
            alu_ovf    = add_ovf;
            alu_carry  = sum[MSB+1];
         end
         3'b110: begin
            alu_result = diff[MSB:0];
            alu_ovf    = sub_ovf;
            alu_carry  = diff[MSB+1];
         end
         // Signed less-than corrects the difference sign by the overflow.
         3'b111: begin
            alu_result = {{MSB{1'b0}}, diff[MSB] ^ sub_ovf};
            alu_ovf    = sub_ovf;
         end
         3'b011:  alu_result = {{MSB{1'b0}}, ~diff[MSB+1]};
         3'b100:  alu_result = a_q ^ b_q;
         default: alu_result = ~(a_q | b_q);
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gid_d        = gid_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      result_d     = result_q;
      flags_d      = flags_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               req0_ready   = ~grant_id;
               req1_ready   = grant_id;
               gid_d        = grant_id;
               last_grant_d = grant_id;
               a_d          = grant_id ? req1_a  : req0_a;
               b_d          = grant_id ? req1_b  : req0_b;
               op_d         = grant_id ? req1_op : req0_op;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            flags_d  = {alu_result == '0, alu_ovf, alu_carry};
            state_d  = RESP;
         end
         RESP: begin
            if (gid_q ? rsp1_ready : rsp0_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gid_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         result_q     <= '0;
         flags_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gid_q        <= gid_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
      end
   end

   assign rsp0_valid  = (state_q == RESP) && !gid_q;
   assign rsp1_valid  = (state_q == RESP) && gid_q;
   assign rsp0_result = result_q;
   assign rsp1_result = result_q;
   assign rsp0_flags  = flags_q;
   assign rsp1_flags  = flags_q;
   assign busy        = (state_q != IDLE);

endmodule
